// File: rtl/cim_pkg.sv
// ---------------------------------------------------------------------------
// cim_pkg
// Shared geometry and types for the basic_gemm_cim compute-in-memory block.
//   - array geometry: 16 rows x 64 columns of 32-bit weight words
//   - each word packs four signed int8 lanes, lane k in bits [8k+7:8k]
//   - accumulators are 32-bit two's complement, one per row
// No ports (package).
// ---------------------------------------------------------------------------
package cim_pkg;

  localparam int CIM_ROWS = 16;
  localparam int CIM_COLS = 64;
  localparam int LANE_W   = 8;
  localparam int LANES    = 4;
  localparam int ACC_W    = 32;
  localparam int WORD_W   = LANE_W * LANES;
  localparam int PROD_W   = 2 * LANE_W;
  localparam int ROW_AW   = $clog2(CIM_ROWS);
  localparam int COL_AW   = $clog2(CIM_COLS);

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ACC_W-1:0]  acc_t;

  // One accumulator per row, packed so a whole bank can be cleared with '0.
  typedef acc_t [CIM_ROWS-1:0] acc_array_t;

  // Sign-extend one lane product up to accumulator width.
  function automatic acc_t sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/basic_gemm_cim_if.sv
// ---------------------------------------------------------------------------
// basic_gemm_cim_if
// Command bus of the compute-in-memory block. There is no handshake: every
// cycle with cs=1 is one accepted command.
//   cs, write, cim, partial_sum, reset_output : command strobes
//   output_reg  [3:0]  : accumulator selected onto cim_output
//   address     [31:0] : row in [9:6], column in [5:0], upper bits unused
//   input_data  [31:0] : write data, or activation vector for cim
//   debug              : accumulator dump request (only with CIM_DEBUG_EN)
//   cim_output  [31:0] : registered value of the selected accumulator
// Modports: master (drives commands), slave (the CIM block).
// ---------------------------------------------------------------------------
interface basic_gemm_cim_if;

  logic        cs;
  logic        write;
  logic        cim;
  logic        partial_sum;
  logic        reset_output;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        debug;
  logic [31:0] cim_output;

  modport master (
    output cs, write, cim, partial_sum, reset_output,
    output output_reg, address, input_data, debug,
    input  cim_output
  );

  modport slave (
    input  cs, write, cim, partial_sum, reset_output,
    input  output_reg, address, input_data, debug,
    output cim_output
  );

endinterface

// File: rtl/cim_dot4.sv
// ---------------------------------------------------------------------------
// cim_dot4
// Four-lane signed int8 dot product of one weight word against the
// activation word, sign-extended to accumulator width. Purely combinational.
//   weight_word [31:0] : four signed int8 weights
//   act_word    [31:0] : four signed int8 activations
//   dot         [31:0] : sum of the four lane products
// ---------------------------------------------------------------------------
module cim_dot4
  import cim_pkg::*;
(
  input  word_t weight_word,
  input  word_t act_word,
  output acc_t  dot
);

  logic [PROD_W-1:0] prod [LANES];

  // Lanes are widened to product width before multiplying so the low
  // PROD_W bits of the product are the exact signed int8 x int8 result
  // (the largest magnitude, -128 * -128 = 16384, still fits).
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] p_s;

    assign w_ext = {{(PROD_W-LANE_W){weight_word[k*LANE_W+LANE_W-1]}},
                    weight_word[k*LANE_W +: LANE_W]};
    assign a_ext = {{(PROD_W-LANE_W){act_word[k*LANE_W+LANE_W-1]}},
                    act_word[k*LANE_W +: LANE_W]};
    assign p_s     = w_ext * a_ext;
    assign prod[k] = p_s;
  end

  always_comb begin
    dot = '0;
    for (int k = 0; k < LANES; k++) begin
      dot = dot + sext_prod(prod[k]);
    end
  end

endmodule

// File: rtl/basic_gemm_cim.sv
// ---------------------------------------------------------------------------
// basic_gemm_cim
// Compute-in-memory GEMM tile: a 16x64 array of packed int8x4 weight words
// with one 32-bit accumulator per row. A cim strobe computes, for all rows
// at once, the dot product of the addressed column against input_data and
// either accumulates into or overwrites the row accumulator.
//   clk, rst : clock and synchronous active-high reset
//   bus      : basic_gemm_cim_if.slave command bus (see interface header)
// rst clears accumulators and cim_output but never the weight array.
// Optional feature: define CIM_DEBUG_EN to print all accumulators (signed
// decimal, one line per row) on every cycle with debug=1. Without the macro
// the debug input is accepted and ignored.
// ---------------------------------------------------------------------------
module basic_gemm_cim
  import cim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  basic_gemm_cim_if.slave  bus
);

  word_t      weight_mem [CIM_ROWS][CIM_COLS];
  acc_array_t acc_q, acc_d;
  acc_array_t dot_all;
  acc_t       cim_output_q, cim_output_d;

  logic [ROW_AW-1:0] row_sel;
  logic [COL_AW-1:0] col_sel;
  logic              do_write, do_cim, do_clear;

  // Address bits above the row field carry no meaning for this tile.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[31:ROW_AW+COL_AW];

  assign row_sel  = bus.address[COL_AW +: ROW_AW];
  assign col_sel  = bus.address[COL_AW-1:0];
  assign do_write = bus.cs & bus.write;
  assign do_cim   = bus.cs & bus.cim;
  assign do_clear = bus.cs & bus.reset_output;

  // One dot-product unit per row, all reading the same column. They see the
  // current array contents, so a same-cycle write is not yet visible.
  for (genvar r = 0; r < CIM_ROWS; r++) begin : g_row
    cim_dot4 u_dot4 (
      .weight_word (weight_mem[r][col_sel]),
      .act_word    (bus.input_data),
      .dot         (dot_all[r])
    );
  end

  // Weight storage is a plain memory with no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      weight_mem[row_sel][col_sel] <= bus.input_data;
    end
  end

  // A clear in the same cycle as a cim behaves like an overwrite: the
  // cleared accumulator plus the dot product is just the dot product.
  always_comb begin
    acc_d = acc_q;
    for (int r = 0; r < CIM_ROWS; r++) begin
      if (do_cim) begin
        if (bus.partial_sum && !do_clear) begin
          acc_d[r] = acc_q[r] + dot_all[r];
        end else begin
          acc_d[r] = dot_all[r];
        end
      end else if (do_clear) begin
        acc_d[r] = '0;
      end
    end
    cim_output_d = acc_d[bus.output_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cim_output_q <= '0;
    end else begin
      acc_q        <= acc_d;
      cim_output_q <= cim_output_d;
    end
  end

  assign bus.cim_output = cim_output_q;

`ifdef CIM_DEBUG_EN
  // Dump of the accumulator bank as it stands at this edge.
  always_ff @(posedge clk) begin
    if (!rst && bus.debug) begin
      for (int r = 0; r < CIM_ROWS; r++) begin
        $display("%0d: %0d", r, $signed(acc_q[r]));
      end
    end
  end
`else
  logic unused_debug;
  assign unused_debug = bus.debug;
`endif

endmodule

// File: tb/tb_basic_gemm_cim.sv
// ---------------------------------------------------------------------------
// tb_basic_gemm_cim
// Directed testbench for basic_gemm_cim. Commands are applied one cycle at a
// time, and cim_output is sampled 1 time unit after the rising edge that
// follows each command. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_basic_gemm_cim;

  logic clk = 1'b0;
  logic rst;

  basic_gemm_cim_if bus ();

  basic_gemm_cim dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Hold one command for the given number of cycles, then return 1 time unit
  // after the last edge with all strobes dropped (output_reg is kept).
  task automatic applyStimulus(input logic cs, input logic wr, input logic cm,
                               input logic ps, input logic ro,
                               input logic [3:0] oreg,
                               input logic [31:0] addr,
                               input logic [31:0] data,
                               input int cycles);
    bus.cs           = cs;
    bus.write        = wr;
    bus.cim          = cm;
    bus.partial_sum  = ps;
    bus.reset_output = ro;
    bus.output_reg   = oreg;
    bus.address      = addr;
    bus.input_data   = data;
    repeat (cycles) @(posedge clk);
    #1;
    bus.cs           = 1'b0;
    bus.write        = 1'b0;
    bus.cim          = 1'b0;
    bus.partial_sum  = 1'b0;
    bus.reset_output = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] expected);
    vectors++;
    assert (bus.cim_output === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
             tag, bus.cim_output, expected);
    end
  endtask

  // Idle cycle that just selects a row, so cim_output shows acc[r].
  task automatic readRow(input logic [3:0] r);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r, 32'h0, 32'h0, 1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.cs           = 1'b0;
    bus.write        = 1'b0;
    bus.cim          = 1'b0;
    bus.partial_sum  = 1'b0;
    bus.reset_output = 1'b0;
    bus.output_reg   = 4'd0;
    bus.address      = 32'h0;
    bus.input_data   = 32'h0;
    bus.debug        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'h0);
    rst = 1'b0;

    // Every accumulator reads zero after reset.
    for (int r = 0; r < 16; r++) begin
      readRow(4'(r));
      checkOutput($sformatf("reset_read_%0d", r), 32'h0);
    end

    // Single MAC: col 5 zeroed in all rows, row 3 = 01 02 03 04.
    for (int r = 0; r < 16; r++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3,
                    (32'(r) << 6) | 32'd5, (r == 3) ? 32'h01020304 : 32'h0, 1);
    end
    // Upper address bits are junk but col 5 is selected.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h12345805, 32'h01010101, 1);
    checkOutput("single_mac_row3", 32'd10);
    readRow(4'd4);
    checkOutput("single_mac_row4", 32'h0);
    readRow(4'd15);
    checkOutput("single_mac_row15", 32'h0);

    // Signed accumulate: (-128)*(-128)*4 = 65536 per cim.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h80808080, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0, 32'h0, 1);
    checkOutput("clear_row0", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 32'h80808080, 1);
    checkOutput("signed_acc_1", 32'd65536);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 32'h80808080, 1);
    checkOutput("signed_acc_2", 32'd131072);

    // Overwrite vs clear on row 2: col 10 weight 7, col 11 weight 5.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h8A, 32'h00000007, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h8B, 32'h00000005, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h8A, 32'h00000001, 1);
    checkOutput("row2_set_7", 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h8B, 32'h00000001, 1);
    checkOutput("row2_overwrite_5", 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h8A, 32'h00000001, 1);
    checkOutput("row2_accumulate_12", 32'd12);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 32'h8B, 32'h00000001, 1);
    checkOutput("row2_clear_with_cim", 32'd5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h8A, 32'h000000FF, 1);
    checkOutput("row2_negative_dot", 32'hFFFFFFF9);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h0, 32'h0, 1);
    checkOutput("row2_clear_alone", 32'h0);
    readRow(4'd0);
    checkOutput("row0_after_clear", 32'h0);

    // Collision on row 4 col 20: cim sees the old weight.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 32'h114, 32'h00000002, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 32'h114, 32'h00000001, 1);
    checkOutput("collision_before", 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h114, 32'h00000009, 1);
    checkOutput("collision_old_weight", 32'd18);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 32'h114, 32'h00000001, 1);
    checkOutput("collision_new_weight", 32'd9);

    // cs=0: write, cim and clear all ignored, output still tracks acc[4].
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 32'h114, 32'h00000064, 1);
    checkOutput("cs0_no_change", 32'd9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 32'h114, 32'h00000001, 1);
    checkOutput("cs0_write_ignored", 32'd9);

    // Wrap-around on row 1: col 30 = all -128, col 31 = 16 (high addr junk).
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h5E, 32'h80808080, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'hFFFFFC5F, 32'h00000010, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 32'h0, 32'h0, 1);
    checkOutput("row1_cleared", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h5E, 32'h80808080, 32768);
    checkOutput("row1_reach_2pow31", 32'h80000000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h5F, 32'h000000FF, 1);
    checkOutput("row1_wrap_down", 32'h7FFFFFF0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h5F, 32'h00000002, 1);
    checkOutput("row1_wrap_up", 32'h80000010);

    // rst overrides a same-cycle cim and leaves the weights intact.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h5F, 32'h00000002, 1);
    rst = 1'b0;
    checkOutput("rst_override", 32'h0);
    readRow(4'd1);
    checkOutput("rst_cleared_row1", 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'h5, 32'h01010101, 1);
    checkOutput("weights_survive_rst", 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
